// File: rtl/key_evt_fifo.sv
// key_evt_fifo: key-event buffer between the matrix scanner and the MCU.
//   Buffers 8-bit key codes in a DEPTH-entry FIFO. The MCU drains one code per
//   rising edge of pop_i. int_o is raised on fill level, on a stale non-empty
//   timeout, or on a sticky overflow.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   key_i8/key_vld_i  scanner push (one-cycle strobe)
//   pop_i             MCU read strobe (edge-detected, any width)
//   clr_i             flush request (level)
//   dat_o8            head code, 8'h00 when empty
//   cnt_o4            occupancy, zero-extended
//   empty_o/full_o    occupancy flags
//   ovf_o             sticky push-while-full flag
//   int_o             level interrupt
module key_evt_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int INT_LEVEL = 4,
  parameter int TMO_CYC   = 50000,
  parameter int TW        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] key_i8,
  input  logic       key_vld_i,
  input  logic       pop_i,
  input  logic       clr_i,
  output logic [7:0] dat_o8,
  output logic [3:0] cnt_o4,
  output logic       empty_o,
  output logic       full_o,
  output logic       ovf_o,
  output logic       int_o
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          tmo, tmo_nxt, ovf_nxt, int_nxt;
  logic          pop_q, pop_edge, pop_ok, push, is_empty, is_full;
  logic [7:0]    head_nxt;

  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == (AW+1)'(DEPTH));
    pop_edge = pop_i & ~pop_q;
    pop_ok   = pop_edge & ~is_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push     = key_vld_i & (~is_full | pop_ok);
    rd_nxt   = rd_ptr + AW'(pop_ok);
    wr_nxt   = wr_ptr + AW'(push);
    cnt_nxt  = cnt + (AW+1)'(push) - (AW+1)'(pop_ok);
    ovf_nxt  = ovf_o | (key_vld_i & is_full & ~pop_ok);

    // Stale timer: any activity or an empty FIFO restarts it; it stops once
    // the flag is set so it never wraps.
    tmr_nxt = tmr;
    tmo_nxt = tmo;
    if (push | pop_ok | is_empty)
      tmr_nxt = '0;
    else if ((cnt < (AW+1)'(INT_LEVEL)) && !tmo) begin
      tmr_nxt = tmr + 1'b1;
      if (tmr_nxt == TW'(TMO_CYC - 1))
        tmo_nxt = 1'b1;
    end
    if (cnt_nxt == '0)
      tmo_nxt = 1'b0;

    // Head of the new state; bypass the write when the pushed code lands in
    // the slot the read pointer will point at (push into empty FIFO).
    if (cnt_nxt == '0)
      head_nxt = 8'h00;
    else if (push && (wr_ptr == rd_nxt))
      head_nxt = key_i8;
    else
      head_nxt = mem[rd_nxt];

    int_nxt = (cnt_nxt >= (AW+1)'(INT_LEVEL)) | tmo_nxt | ovf_nxt;
  end

  // Storage is not reset; stale contents are never visible past the count.
  always_ff @(posedge clk_i)
    if (!rst_i && !clr_i && push)
      mem[wr_ptr] <= key_i8;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pop_q   <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      tmr     <= '0;
      tmo     <= 1'b0;
      ovf_o   <= 1'b0;
      dat_o8  <= 8'h00;
      cnt_o4  <= 4'd0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
      int_o   <= 1'b0;
    end else begin
      pop_q <= pop_i;
      if (clr_i) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
        tmr     <= '0;
        tmo     <= 1'b0;
        ovf_o   <= 1'b0;
        dat_o8  <= 8'h00;
        cnt_o4  <= 4'd0;
        empty_o <= 1'b1;
        full_o  <= 1'b0;
        int_o   <= 1'b0;
      end else begin
        rd_ptr  <= rd_nxt;
        wr_ptr  <= wr_nxt;
        cnt     <= cnt_nxt;
        tmr     <= tmr_nxt;
        tmo     <= tmo_nxt;
        ovf_o   <= ovf_nxt;
        dat_o8  <= head_nxt;
        cnt_o4  <= 4'(cnt_nxt);
        empty_o <= (cnt_nxt == '0);
        full_o  <= (cnt_nxt == (AW+1)'(DEPTH));
        int_o   <= int_nxt;
      end
    end
  end

endmodule
